// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with valid/ready handshake and flush.
// Optional saturating performance counters are enabled by defining STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 137,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ_state
`ifdef STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Handshake: a beat moves on a port in any cycle where valid and ready are both
  // high at the rising edge; valid never waits on ready, and in_ready comes straight
  // from the occupancy register so out_ready has no combinational path to it.

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e              occ_q;
  occ_e              occ_d;
  logic              main_valid;
  logic              skid_valid;
  logic              accept;
  logic              drain;
  logic              load_main;
  logic              load_skid;
  logic              skid_to_main;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign main_valid = (occ_q != OCC_EMPTY);
  assign skid_valid = (occ_q == OCC_TWO);
  assign in_ready   = !skid_valid;
  assign out_valid  = main_valid;
  assign accept     = in_valid & in_ready & !flush;
  assign drain      = main_valid & out_ready;
  assign occ_state  = occ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= OCC_EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  always_comb begin
    occ_d        = occ_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d     = OCC_ONE;
            load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          case ({accept, drain})
            2'b10: begin
              occ_d     = OCC_TWO;
              load_skid = 1'b1;
            end
            2'b01: occ_d = OCC_EMPTY;
            2'b11: load_main = 1'b1;
            default: occ_d = OCC_ONE;
          endcase
        end
        OCC_TWO: begin
          // in_ready is low here, so no accept can coincide with the skid move
          if (drain) begin
            occ_d        = OCC_ONE;
            skid_to_main = 1'b1;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Payload registers only move on an accept or a skid transfer; bubbles leave them untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (skid_to_main) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  assign out_ctrl = main_valid ? main_ctrl : '0;
  assign out_data = main_data;

`ifdef STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
      if (!main_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 9, width of control bundle (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD[3:0]).
REQ-002 SHALL have parameter DATA_W, default 137, width of payload bundle (PC, Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest).
REQ-003 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous squash of all held and incoming entries (branch taken).
REQ-007 in_valid  in  1  upstream entry present; low = bubble (hazard).
REQ-008 in_ready  out  1  stage can accept an entry this cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-010 in_data  in  DATA_W  upstream payload bundle.
REQ-011 out_valid  out  1  downstream entry present.
REQ-012 out_ready  in  1  downstream accepts entry this cycle.
REQ-013 out_ctrl  out  CTRL_W  control bundle; forced zero whenever out_valid=0.
REQ-014 out_data  out  DATA_W  payload bundle; holds last value when out_valid=0.
REQ-015 stall_cnt, flush_cnt, bubble_cnt  out  CNT_W each  present only under STAGE_PERF_EN.

Function
REQ-016 SHALL hold two entries: main (drives outputs) and skid; each has a valid bit.
REQ-017 in_ready SHALL equal !skid_valid (registered, no combinational path from out_ready).
REQ-018 Accept = in_valid & in_ready & !flush; drain = out_valid & out_ready.
REQ-019 Accept with main empty, or main draining and skid empty: entry SHALL load into main; latency 1 cycle in_valid to out_valid.
REQ-020 Accept with main full and not draining: entry SHALL load into skid.
REQ-021 Drain with skid full: skid SHALL move into main next cycle; an accept that cycle is impossible (in_ready=0).
REQ-022 Drain with skid empty and no accept: main valid SHALL clear.
REQ-023 Occupancy states EMPTY(0), ONE(main), TWO(main+skid); only transitions EMPTY<->ONE<->TWO; EMPTY->TWO never.
REQ-024 flush SHALL clear both valid bits next cycle regardless of in_valid/out_ready; incoming entry that cycle discarded; state->EMPTY.
REQ-025 Payload registers SHALL load only on accept/skid transfer; otherwise hold (no toggle on bubbles).
REQ-026 Entries SHALL emerge in acceptance order; no duplication, no loss except on flush.

Reset
REQ-027 On rst low: main and skid valid=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1 immediately (asynchronous).
REQ-028 Reset mid-transfer SHALL discard all entries; first accept after rst release behaves as from EMPTY.
REQ-029 Counters SHALL reset to 0.

Configuration
REQ-030 Macro STAGE_PERF_EN defined: stall_cnt +1 per cycle out_valid & !out_ready; flush_cnt +1 per flush cycle; bubble_cnt +1 per cycle out_valid=0; all saturate at 2^CNT_W-1, no wrap.
REQ-031 Macro STAGE_PERF_EN undefined: counter ports and logic absent; datapath behaviour identical.

Verification
REQ-032 After reset, in_valid=1, in_ctrl=9'h1A5, out_ready=1 -> out_valid=1, out_ctrl=9'h1A5 one cycle later; in_ready stays 1.
REQ-033 out_ready=0, push A,B,C back-to-back -> A in main, B in skid, in_ready=0 when C offered, C held upstream; out_ready=1 -> A,B,C out in order on consecutive cycles.
REQ-034 Stage in TWO, assert flush 1 cycle with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, flush_cnt=1.
REQ-035 in_valid=0 for 3 cycles with out_ready=1 -> out_ctrl=0, out_data unchanged, bubble_cnt=3.
REQ-036 CNT_W=4, out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15, holds 15.
REQ-037 rst low while in TWO -> out_valid=0, in_ready=1 before next clock edge; after release push D -> D appears alone.
